note_stream_gen_mc: RTL and testbench

//  Multi-channel note stream generator with event output.
//  Per channel: merges a global octave and a signed per-channel octave offset with the channel's note code.

---
 rtl/note_stream_gen_mc.sv | 147 ++++++++++++++
 tb/tb_note_stream_gen_mc.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_stream_gen_mc.sv
// Multi-channel note stream generator: per-channel {octave,note} words plus a
// queued note-on/note-off event stream for the voice allocator.
module note_stream_gen_mc #(
    parameter int NUM_CH     = 2,
    parameter int NOTE_W     = 6,
    parameter int OCT_W      = 3,
    parameter int FIFO_DEPTH = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int WORD_W    = OCT_W + NOTE_W,
    localparam int EVT_W     = 1 + CH_W + WORD_W,
    localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [OCT_W-1:0]           octave,
    input  logic [2*NUM_CH-1:0]        oct_ofs,
    input  logic [NOTE_W*NUM_CH-1:0]   notes_in,
    output logic [WORD_W*NUM_CH-1:0]   stream_out,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [EVT_W-1:0]           evt_data,
    output logic [LVL_W-1:0]           fifo_level,
    output logic                       ovf,
    input  logic                       ovf_clr
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Event handshake: evt_data holds the FIFO head whenever evt_valid is high and
    // stays stable until the cycle where evt_valid && evt_ready, which pops it.

    logic [WORD_W-1:0] cur      [NUM_CH];
    logic [WORD_W-1:0] nw       [NUM_CH];
    logic [WORD_W:0]   new_evt  [NUM_CH];
    logic [WORD_W:0]   pend_evt [NUM_CH];
    logic [NUM_CH-1:0] chg;
    logic [NUM_CH-1:0] pend_v;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] lost;
    logic [CH_W-1:0]   grant_ch;
    logic              found;
    logic              full;
    logic              push;
    logic              pop;
    logic [EVT_W-1:0]  push_data;

    logic [EVT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        logic signed [OCT_W+1:0] oct_sum;
        logic [OCT_W-1:0]        oct_eff;
        logic [NOTE_W-1:0]       note;

        assign note    = notes_in[k*NOTE_W +: NOTE_W];
        assign oct_sum = $signed({2'b00, octave})
                       + $signed({{OCT_W{oct_ofs[2*k+1]}}, oct_ofs[2*k +: 2]});

        // Saturate rather than wrap so an offset never jumps to the far octave.
        always_comb begin
            if (oct_sum < 0)
                oct_eff = '0;
            else if (oct_sum > $signed({2'b00, {OCT_W{1'b1}}}))
                oct_eff = '1;
            else
                oct_eff = oct_sum[OCT_W-1:0];
        end

        assign nw[k]      = (note == '0) ? '0 : {oct_eff, note};
        assign chg[k]     = (nw[k] != cur[k]);
        assign new_evt[k] = (nw[k] != '0) ? {1'b1, nw[k]} : {1'b0, cur[k]};
        assign lost[k]    = chg[k] & pend_v[k] & ~grant[k];
        assign stream_out[k*WORD_W +: WORD_W] = cur[k];
    end

    assign full = (fifo_level == LVL_W'(FIFO_DEPTH));

    always_comb begin
        grant    = '0;
        grant_ch = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!found && pend_v[k] && !full) begin
                grant[k] = 1'b1;
                grant_ch = CH_W'(k);
                found    = 1'b1;
            end
        end
    end

    assign push      = |grant;
    assign push_data = {pend_evt[grant_ch][WORD_W], grant_ch, pend_evt[grant_ch][WORD_W-1:0]};
    assign evt_valid = (fifo_level != '0);
    assign pop       = evt_valid & evt_ready;
    assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cur[k]      <= '0;
                pend_evt[k] <= '0;
            end
            pend_v <= '0;
            ovf    <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                cur[k] <= nw[k];
                // A fresh event re-arms the register even if it was just granted.
                if (chg[k]) begin
                    pend_v[k]   <= 1'b1;
                    pend_evt[k] <= new_evt[k];
                end else if (grant[k]) begin
                    pend_v[k] <= 1'b0;
                end
            end
            if (|lost)
                ovf <= 1'b1;
            else if (ovf_clr)
                ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

endmodule

// File: tb/tb_note_stream_gen_mc.sv
// Randomized and directed bench for note_stream_gen_mc with a queue-based
// reference model and a decoupled event monitor.
module tb_note_stream_gen_mc;

    localparam int NUM_CH     = 2;
    localparam int NOTE_W     = 6;
    localparam int OCT_W      = 3;
    localparam int FIFO_DEPTH = 8;
    localparam int CH_W       = 1;
    localparam int WORD_W     = OCT_W + NOTE_W;
    localparam int EVT_W      = 1 + CH_W + WORD_W;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic                      clk;
    logic                      reset;
    logic [OCT_W-1:0]          octave;
    logic [2*NUM_CH-1:0]       oct_ofs;
    logic [NOTE_W*NUM_CH-1:0]  notes_in;
    logic [WORD_W*NUM_CH-1:0]  stream_out;
    logic                      evt_valid;
    logic                      evt_ready;
    logic [EVT_W-1:0]          evt_data;
    logic [LVL_W-1:0]          fifo_level;
    logic                      ovf;
    logic                      ovf_clr;

    note_stream_gen_mc #(
        .NUM_CH(NUM_CH), .NOTE_W(NOTE_W), .OCT_W(OCT_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .octave(octave), .oct_ofs(oct_ofs),
        .notes_in(notes_in), .stream_out(stream_out), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_data(evt_data), .fifo_level(fifo_level),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: expected FIFO contents as a queue
    logic [EVT_W-1:0] exp_q[$];
    int m_stream[NUM_CH];
    int m_pv[NUM_CH];
    int m_pg[NUM_CH];
    int m_pw[NUM_CH];
    int m_popped = 0;
    int movf     = 0;
    int m_lvl, m_g, m_note, m_ofs, m_oe, m_nw, m_set;

    initial begin
        for (int k = 0; k < NUM_CH; k++) begin
            m_stream[k] = 0; m_pv[k] = 0; m_pg[k] = 0; m_pw[k] = 0;
        end
    end

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            exp_q.delete();
            m_popped = 0;
            movf     = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_stream[k] = 0; m_pv[k] = 0; m_pg[k] = 0; m_pw[k] = 0;
            end
        end else begin
            m_lvl    = exp_q.size() + m_popped;
            m_popped = 0;
            m_g      = -1;
            if (m_lvl < FIFO_DEPTH)
                for (int k = 0; k < NUM_CH; k++)
                    if (m_g < 0 && m_pv[k] != 0) m_g = k;
            if (m_g >= 0) begin
                exp_q.push_back(EVT_W'((m_pg[m_g] << (CH_W + WORD_W)) | (m_g << WORD_W) | m_pw[m_g]));
                m_pv[m_g] = 0;
            end
            m_set = 0;
            for (int k = 0; k < NUM_CH; k++) begin
                m_note = int'(notes_in[k*NOTE_W +: NOTE_W]);
                m_ofs  = int'(oct_ofs[2*k +: 2]);
                if (m_ofs >= 2) m_ofs = m_ofs - 4;
                m_oe = int'(octave) + m_ofs;
                if (m_oe < 0) m_oe = 0;
                if (m_oe > (1 << OCT_W) - 1) m_oe = (1 << OCT_W) - 1;
                m_nw = (m_note == 0) ? 0 : (m_oe * (1 << NOTE_W) + m_note);
                if (m_nw != m_stream[k]) begin
                    if (m_pv[k] != 0) m_set = 1;
                    m_pv[k] = 1;
                    m_pg[k] = (m_nw != 0) ? 1 : 0;
                    m_pw[k] = (m_nw != 0) ? m_nw : m_stream[k];
                end
                m_stream[k] = m_nw;
            end
            if (m_set != 0) movf = 1;
            else if (ovf_clr) movf = 0;
        end
    end

    // Monitor: compares outputs each negedge and pops on handshake
    logic [WORD_W*NUM_CH-1:0] exp_stream;
    always @(negedge clk) begin
        for (int k = 0; k < NUM_CH; k++)
            exp_stream[k*WORD_W +: WORD_W] = WORD_W'(m_stream[k]);
        check("stream_out", 32'(stream_out), 32'(exp_stream));
        check("fifo_level", 32'(fifo_level), 32'(exp_q.size()));
        check("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
        check("ovf", 32'(ovf), 32'(movf));
        if (evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                check("evt_unexpected", 32'(evt_data), 32'h0);
            end else begin
                check("evt_data", 32'(evt_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                m_popped = 1;
            end
        end
    end

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        evt_ready = 1'b1;
        repeat (n) step();
    endtask

    initial begin
        reset = 1'b0; octave = '0; oct_ofs = '0; notes_in = '0;
        evt_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) step();
        check("rst_stream", 32'(stream_out), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        reset = 1'b1;
        repeat (2) step();

        // First note-on: word and event latency
        octave = 3'd3; evt_ready = 1'b1;
        repeat (3) step();
        notes_in[5:0] = 6'd5;
        step();
        check("t2_stream0", 32'(stream_out[8:0]), 32'h0C5);
        check("t2_valid_early", 32'(evt_valid), 32'h0);
        step();
        check("t2_valid", 32'(evt_valid), 32'h1);
        check("t2_data", 32'(evt_data), 32'h4C5);

        // Octave clamping at both ends
        octave = 3'd7; oct_ofs[1:0] = 2'b01;
        step();
        check("t3_oct_hi", 32'(stream_out[8:6]), 32'h7);
        octave = 3'd0; oct_ofs[1:0] = 2'b10;
        step();
        check("t3_oct_lo", 32'(stream_out[8:6]), 32'h0);
        drain(6);

        // Simultaneous changes on both channels
        octave = 3'd4; oct_ofs = '0;
        notes_in = {6'd7, 6'd9};
        step();
        step();
        check("t4_ch0_data", 32'(evt_data), 32'h509);
        step();
        check("t4_ch1_data", 32'(evt_data), 32'h707);
        check("t4_no_ovf", 32'(ovf), 32'h0);

        // Saturation, overflow and clear, then in-order drain
        notes_in = '0; ovf_clr = 1'b1;
        drain(6);
        ovf_clr = 1'b0; evt_ready = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            notes_in[5:0] = NOTE_W'(i);
            step();
        end
        check("t5_level_full", 32'(fifo_level), 32'h8);
        check("t5_ovf_set", 32'(ovf), 32'h1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(ovf), 32'h0);
        drain(12);
        check("t5_drained", 32'(fifo_level), 32'h0);

        // Note-off carries the released word; push+pop at level 3
        octave = 3'd2; notes_in = '0;
        drain(6);
        evt_ready = 1'b0;
        notes_in[11:6] = 6'd10;
        step();
        notes_in[11:6] = 6'd0;
        step();
        check("t6_stream1", 32'(stream_out[17:9]), 32'h0);
        step();
        evt_ready = 1'b1;
        check("t6_on_data", 32'(evt_data), 32'h68A);
        step();
        check("t6_off_data", 32'(evt_data), 32'h28A);
        drain(4);
        evt_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            notes_in[5:0] = NOTE_W'(i);
            step();
        end
        check("t6_level3", 32'(fifo_level), 32'h3);
        evt_ready = 1'b1;
        step();
        check("t6_pushpop", 32'(fifo_level), 32'h3);

        // Random traffic with an asynchronous reset in the middle
        for (int cyc = 0; cyc < 1200; cyc++) begin
            for (int k = 0; k < NUM_CH; k++)
                if ($urandom_range(0, 3) == 0)
                    notes_in[k*NOTE_W +: NOTE_W] =
                        ($urandom_range(0, 2) == 0) ? NOTE_W'(0) : NOTE_W'($urandom_range(1, 63));
            if ($urandom_range(0, 15) == 0) octave = OCT_W'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) oct_ofs = (2*NUM_CH)'($urandom_range(0, 15));
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            if (cyc == 600) begin
                reset = 1'b0;
                #1;
                check("t1_async_stream", 32'(stream_out), 32'h0);
                check("t1_async_valid", 32'(evt_valid), 32'h0);
                check("t1_async_level", 32'(fifo_level), 32'h0);
                check("t1_async_ovf", 32'(ovf), 32'h0);
                step();
                check("t1_hold_valid", 32'(evt_valid), 32'h0);
                step();
                reset = 1'b1;
            end
            step();
        end

        ovf_clr = 1'b0;
        drain(30);
        check("end_empty", 32'(fifo_level), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
